mux_alu_src_pipe: RTL
=====================

Name: mux_alu_src_pipe

Overview:
- Parametrised successor to the ALU operand-B source mux: NUM_IN-way selector over WIDTH-bit operands, with slot 1 hard-wired to the constant CONST_VAL (PC increment).
- Output is registered behind a 2-entry skid buffer with valid/ready handshake. This lets the ALU stage stall without losing a selected operand.
- Sits between the register file / immediate-extend logic and the ALU in the multicycle datapath.

Parameters:
- WIDTH, 32, operand width in bits.
- NUM_IN, 4, number of selectable slots (2..8); slot 1 is always CONST_VAL.
- CONST_VAL, 4, constant driven for slot 1, truncated/zero-extended to WIDTH.
- SEL_W, $clog2(NUM_IN), selector width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- sel  input  SEL_W  slot select, sampled with in_valid.
- data_in  input  NUM_IN*WIDTH  packed operands; slot k = data_in[k*WIDTH +: WIDTH]; slot 1 bits ignored.
- in_valid  input  1  upstream offers sel/data_in this cycle.
- in_ready  output  1  block accepts this cycle.
- out_data  output  WIDTH  selected operand.
- out_sel  output  SEL_W  selector that produced out_data (tag for debug/forwarding).
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  ALU consumes this cycle.
- err  output  1  sticky illegal-select flag (only with the optional feature; otherwise tied 0).

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is asynchronous, active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, in_ready=1, err=0, skid entry empty, state=EMPTY.
- Selection (combinational, pre-register):
  - sel==1 -> CONST_VAL.
  - sel==k (k<NUM_IN, k!=1) -> slot k.
  - sel>=NUM_IN -> all-zero.
- Accept when in_valid && in_ready; consume when out_valid && out_ready.
- Latency: 1 cycle from accept to out_valid when the buffer is empty.
- State machine, with the skid register used only in FULL:
  - EMPTY: on accept, load main register -> BUSY.
  - BUSY:
    - accept && !consume -> load skid -> FULL.
    - accept && consume -> reload main -> BUSY.
    - !accept && consume -> EMPTY.
    - otherwise hold.
  - FULL: in_ready=0. On consume, move skid to main -> BUSY; otherwise hold both.
- in_ready is a register output (=state!=FULL), not combinationally dependent on out_ready.
- Ordering: strict FIFO; no entry dropped or duplicated.
- Hold: while out_valid && !out_ready, out_data/out_sel are stable.
- Reset mid-operation: both entries are discarded immediately (async); the first accept is possible in the first cycle after reset deasserts.
- in_valid with in_ready=0: ignored; upstream must hold its values.

Optional Feature:
- MUX_ALU_SEL_CHECK_EN defined:
  - An accept with sel>=NUM_IN sets err=1 the next cycle.
  - err stays set until reset; the all-zero operand still flows through the pipe.
- Undefined: err tied 0; no check logic is synthesised.

Decomposition:
- Shared package (datapath pkg): localparams for ALU-B slot indices (SRC_B_REG=0, SRC_B_CONST=1, SRC_B_IMM=2, SRC_B_IMM_SHL2=3) and the default PC increment constant.
- One natural sub-module: skid_buffer (parametrised payload width = WIDTH+SEL_W, implements the EMPTY/BUSY/FULL FSM). The top holds only the select logic and err.

Test Plan:
- Reset, then sel=0, data slot0=32'hDEADBEEF, in_valid=1, out_ready=1 -> out_valid=1 next cycle with out_data=32'hDEADBEEF, out_sel=0.
- sel=1 with slot1 bits=32'hFFFFFFFF -> out_data=32'd4, irrespective of slot1.
- Backpressure:
  - Sequence: out_ready=0, accept A (sel=2, 32'h10) then B (sel=3, 32'h20).
  - Check: in_ready=0 on the third cycle; A is held stable.
  - Release: raise out_ready -> A then B delivered in consecutive cycles.
  - Then: in_ready returns to 1.
- Full throughput: in_valid=out_ready=1 for 100 random sel/data -> out matches the reference model in order, 1-cycle latency, in_ready never 0.
- NUM_IN=6, sel=7:
  - out_data=0.
  - With MUX_ALU_SEL_CHECK_EN: err=1 next cycle, persisting until reset.
  - Without: err=0.
- Assert reset while FULL -> out_valid=0 and in_ready=1 immediately; no stale entries after deassert.

Source files
------------

// File: rtl/mux_alu_src_pipe_pkg.sv
// Shared datapath definitions for the ALU operand-B source pipe:
// slot indices, the default PC increment and the skid-buffer state type.
package mux_alu_src_pipe_pkg;

  localparam int SRC_B_REG      = 0;
  localparam int SRC_B_CONST    = 1;
  localparam int SRC_B_IMM      = 2;
  localparam int SRC_B_IMM_SHL2 = 3;

  localparam int unsigned PC_INCR = 4;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } skid_state_t;

endpackage

// File: rtl/mux_alu_src_pipe_skid_buffer.sv
// Two-entry skid buffer with valid/ready handshake; the skid entry only
// holds data while the downstream stalls and a second item has arrived.
module mux_alu_src_pipe_skid_buffer
  import mux_alu_src_pipe_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  skid_state_t   state, state_next;
  logic [PW-1:0] main_q, skid_q;
  logic          in_ready_q;
  logic          accept, consume;
  logic          load_main, load_skid, skid_to_main;

  assign accept    = in_valid && in_ready_q;
  assign consume   = (state != EMPTY) && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  // in_ready is registered from the next state so it never depends on out_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next != FULL);
      if (load_main)
        main_q <= in_data;
      else if (skid_to_main)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_data;
    end
  end

  always_comb begin
    state_next   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (accept && !consume) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end else if (accept && consume) begin
          load_main  = 1'b1;
        end else if (consume) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          skid_to_main = 1'b1;
          state_next   = BUSY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

endmodule

// File: rtl/mux_alu_src_pipe.sv
// NUM_IN-way ALU operand-B source select (slot 1 = CONST_VAL) feeding a skid buffer.
// Define MUX_ALU_SEL_CHECK_EN to enable the sticky illegal-select flag err.
module mux_alu_src_pipe
  import mux_alu_src_pipe_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          NUM_IN    = 4,
  parameter int unsigned CONST_VAL = PC_INCR,
  parameter int          SEL_W     = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err
);

  localparam logic [WIDTH-1:0] CONST_W = WIDTH'(CONST_VAL);

  logic [WIDTH-1:0]       sel_data;
  logic [SEL_W+WIDTH-1:0] payload_out;

  // Out-of-range selects fall through to the all-zero default
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (32'(sel) == k)
        sel_data = (k == SRC_B_CONST) ? CONST_W : data_in[k*WIDTH +: WIDTH];
    end
  end

  mux_alu_src_pipe_skid_buffer #(
    .PW (SEL_W + WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_data   ({sel, sel_data}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (payload_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_sel  = payload_out[WIDTH +: SEL_W];
  assign out_data = payload_out[WIDTH-1:0];

`ifdef MUX_ALU_SEL_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else if (in_valid && in_ready && (32'(sel) >= NUM_IN))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
